// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

  localparam int INSTR_BYTES      = 4;
  localparam int DEFAULT_RESET_PC = 0;
  localparam int DEF_PC_W         = 10;
  localparam int DEF_INSTR_W      = 32;

  // One fetch-queue slot at the default widths.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    pc_plus4;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous FIFO holding fetched instructions. Clear wins over push and pop.
// The head output reads zero whenever the queue is empty.
module fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 42
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           push_data_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [W-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push = push_i && (cnt_q != (AW+1)'(DEPTH));
    do_pop  = pop_i && (cnt_q != '0);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!reset && !clear_i && do_push) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, redirect handling, in-flight
// tracking and a fetch queue feeding decode over valid/ready.
// Optional build macro IF_STATS_EN adds fetch_cnt / flush_cnt counters.
//
// Handshake: an entry transfers on a cycle where out_valid && out_ready;
// out_valid never depends on out_ready in the same cycle.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_address,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_address,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_plus4
`ifdef IF_STATS_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + PC_W;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inf_pc4_q, inf_pc4_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic            redirect;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_plus4;
  logic [CW-1:0]   q_count;
  logic [CW:0]     used;
  logic            push, pop;
  logic [EW-1:0]   head;

  assign redirect  = jump || branch_taken;
  assign pc_plus4  = pc_q + PC_W'(INSTR_BYTES);
  assign used      = {1'b0, q_count} + (CW+1)'(inflight_q);
  assign imem_req  = !reset && !redirect && (used < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;
  assign push      = inflight_q && !kill_q;
  assign pop       = out_valid && out_ready;

  // Redirect target (jump over branch) and next PC / in-flight bookkeeping.
  always_comb begin
    target      = jump ? jump_address : branch_address;
    target[1:0] = 2'b00;
    pc_d        = pc_q;
    inf_pc4_d   = inf_pc4_q;
    inflight_d  = imem_req;
    kill_d      = redirect && inflight_q;
    if (redirect) begin
      pc_d = target;
    end else if (imem_req) begin
      pc_d      = pc_plus4;
      inf_pc4_d = pc_plus4;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inf_pc4_q  <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inf_pc4_q  <= inf_pc4_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (redirect),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i ({imem_rdata, inf_pc4_q}),
    .count_o     (q_count),
    .head_o      (head)
  );

  assign out_valid    = (q_count != '0);
  assign out_instr    = head[EW-1:PC_W];
  assign out_pc_plus4 = head[PC_W-1:0];

`ifdef IF_STATS_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  // Issue and redirect counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(imem_req);
      flush_cnt_q <= flush_cnt_q + 32'(redirect);
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit (default parameters). Honours IF_STATS_EN.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_taken = 1'b0;
  logic [9:0]  branch_address = '0;
  logic        jump = 1'b0;
  logic [9:0]  jump_address = '0;
  logic [9:0]  imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [9:0]  out_pc_plus4;
`ifdef IF_STATS_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .jump           (jump),
    .jump_address   (jump_address),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc_plus4   (out_pc_plus4)
`ifdef IF_STATS_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  // Instruction memory contents: word i holds 0x1000_0000 + i.
  function automatic logic [31:0] memf(input logic [9:0] a);
    return 32'h1000_0000 + 32'(a[9:2]);
  endfunction

  // Synchronous-read memory: data for a request appears the next cycle.
  always @(posedge clk) imem_rdata <= imem_req ? memf(imem_addr) : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t cyc=%0d: got=%0h expected=%0h", tag, $time, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction-level view: a list of buffered entries, one optional
  // outstanding request, and the next fetch address.
  if_entry_t   exp_q[$];
  logic [9:0]  m_pc = '0;
  bit          m_inf = 0;
  logic [9:0]  m_inf_pc = '0;
  bit          m_kill = 0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_flush = '0;

  function automatic bit m_req();
    return !reset && !(jump || branch_taken) && ((exp_q.size() + int'(m_inf)) < DEPTH);
  endfunction

  task automatic model_update();
    bit          redir;
    bit          req;
    logic [9:0]  tgt;
    if_entry_t   e;
    redir = jump || branch_taken;
    tgt   = (jump ? jump_address : branch_address) & 10'h3FC;
    req   = m_req();
    if (reset) begin
      exp_q.delete();
      m_pc = '0; m_inf = 0; m_kill = 0; m_fetch = '0; m_flush = '0;
    end else begin
      if (req)   m_fetch = m_fetch + 1;
      if (redir) m_flush = m_flush + 1;
      if (redir) begin
        exp_q.delete();
        m_kill = m_inf;
        m_pc   = tgt;
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (m_inf && !m_kill) begin
          e.instr    = memf(m_inf_pc);
          e.pc_plus4 = m_inf_pc + 10'd4;
          exp_q.push_back(e);
        end
        m_kill = 0;
      end
      if (req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 10'd4;
      end
      m_inf = req;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs at the falling edge, then compare every output with the model.
  task automatic drive(input bit rst, input bit br, input logic [9:0] ba,
                       input bit jp, input logic [9:0] ja, input bit rdy);
    @(negedge clk);
    reset = rst; branch_taken = br; branch_address = ba;
    jump = jp; jump_address = ja; out_ready = rdy;
    #1;
    check("imem_req",  64'(imem_req),  64'(m_req()));
    check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("out_instr", 64'(out_instr), 64'((exp_q.size() != 0) ? exp_q[0].instr : 32'h0));
    check("out_pc4",   64'(out_pc_plus4), 64'((exp_q.size() != 0) ? exp_q[0].pc_plus4 : 10'h0));
`ifdef IF_STATS_EN
    check("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    cyc++;
  endtask

  task automatic plain(input bit rdy);
    drive(0, 0, '0, 0, '0, rdy);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, '0, 0, '0, 0);
      advance();
    end
    cyc = 0;
  endtask

  logic [31:0] next_word;

  // ---------------- stimulus ----------------
  initial begin
    // Unchecked power-on reset so registers leave X before comparisons start.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_update();
    do_reset();

    // Streaming, then a 10-cycle stall, then drain.
    next_word = 32'h1000_0000;
    for (int c = 0; c < 46; c++) begin
      plain(!(c >= 20 && c < 30));
      if (c == 0) begin
        check("first_req",  64'(imem_req), 64'(1));
        check("first_addr", 64'(imem_addr), 64'(0));
        check("c0_valid",   64'(out_valid), 64'(0));
      end
      if (c == 1) check("c1_valid", 64'(out_valid), 64'(0));
      if (c == 2) begin
        check("c2_valid", 64'(out_valid), 64'(1));
        check("c2_instr", 64'(out_instr), 64'(32'h1000_0000));
        check("c2_pc4",   64'(out_pc_plus4), 64'(4));
      end
      if (c == 29) begin
        check("stall_req",   64'(imem_req), 64'(0));
        check("stall_valid", 64'(out_valid), 64'(1));
      end
      if (out_valid && out_ready) begin
        check("seq", 64'(out_instr), 64'(next_word));
        next_word = next_word + 1;
      end
      advance();
    end

    // Branch to 0x40 in cycle 5.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(0, c == 5, 10'h040, 0, '0, 1);
      if (c == 6 || c == 7) check("br_bubble", 64'(out_valid), 64'(0));
      if (c == 8) begin
        check("br_instr", 64'(out_instr), 64'(32'h1000_0010));
        check("br_pc4",   64'(out_pc_plus4), 64'(10'h044));
      end
      advance();
    end

    // Jump and branch together: jump wins.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(0, c == 4, 10'h040, c == 4, 10'h080, 1);
      if (c == 5) check("jmp_addr", 64'(imem_addr), 64'(10'h080));
      if (c == 7) begin
        check("jmp_instr", 64'(out_instr), 64'(32'h1000_0020));
        check("jmp_pc4",   64'(out_pc_plus4), 64'(10'h084));
      end
      advance();
    end

    // Redirect to the top word; the PC wraps to zero.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(0, c == 3, 10'h3FF, 0, '0, 1);
      if (c == 5) check("wrap_addr", 64'(imem_addr), 64'(0));
      if (c == 6) begin
        check("wrap_instr", 64'(out_instr), 64'(32'h1000_00FF));
        check("wrap_pc4",   64'(out_pc_plus4), 64'(0));
      end
      if (c == 7) begin
        check("wrap_next", 64'(out_instr), 64'(32'h1000_0000));
        check("wrap_pc4b", 64'(out_pc_plus4), 64'(4));
      end
      advance();
    end

    // Reset mid-stream together with a redirect.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      plain(1);
      advance();
    end
    drive(1, 1, 10'h040, 1, 10'h080, 1);
    check("rst_redir_req", 64'(imem_req), 64'(0));
    advance();
    plain(1);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_addr",  64'(imem_addr), 64'(0));
`ifdef IF_STATS_EN
    check("rst_fetch", 64'(fetch_cnt), 64'(0));
    check("rst_flush", 64'(flush_cnt), 64'(0));
`endif
    advance();

    // Random traffic: stalls, redirects and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bit rdy;
      rdy = (c % 200 < 40) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 249) == 0,
            $urandom_range(0, 11) == 0, 10'($urandom_range(0, 1023)),
            $urandom_range(0, 23) == 0, 10'($urandom_range(0, 1023)),
            rdy);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
